input_vc_buffer: RTL

//  Receive side of a router link: accepts flits leaving an upstream router's crossbar output port.

---
 rtl/input_vc_buffer_pkg.sv | 10 +
 rtl/vc_fifo.sv | 60 ++++++
 rtl/input_vc_buffer.sv | 103 ++++++++++
 3 files changed

// File: rtl/input_vc_buffer_pkg.sv
// Shared constants for the router input-port VC buffer.
// These mirror the router-wide flit width and the default VC / buffer sizing
// used by the crossbar and allocators.
package input_vc_buffer_pkg;

  localparam int FLIT_DATA_WIDTH   = 16;
  localparam int DEFAULT_NUM_VCS   = 4;
  localparam int DEFAULT_BUF_DEPTH = 4;

endpackage

// File: rtl/vc_fifo.sv
// One first-word-fall-through FIFO holding the flits of a single virtual channel.
// The caller only asserts push/pop when they are legal: push when not full or
// when popping in the same cycle, and pop only when non-empty.
module vc_fifo
  import input_vc_buffer_pkg::*;
#(
  parameter  int WIDTH = FLIT_DATA_WIDTH,
  parameter  int DEPTH = DEFAULT_BUF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Flit storage; deliberately not reset, the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; the count saturates by construction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/input_vc_buffer.sv
// Receive side of a router link: steers incoming flits into per-VC FIFOs,
// exposes every VC head to route compute / switch allocation, pops on grant
// and returns one credit upstream per popped flit, one cycle later.
module input_vc_buffer
  import input_vc_buffer_pkg::*;
#(
  parameter  int NUM_VCS   = DEFAULT_NUM_VCS,
  parameter  int BUF_DEPTH = DEFAULT_BUF_DEPTH,
  localparam int VC_W      = $clog2(NUM_VCS),
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [VC_W-1:0]            in_vc_id,
  input  logic [FLIT_DATA_WIDTH-1:0] in_data,
  input  logic [NUM_VCS-1:0]         vc_pop,
  output logic [FLIT_DATA_WIDTH-1:0] vc_head_data [NUM_VCS-1:0],
  output logic [NUM_VCS-1:0]         vc_head_valid,
  output logic [CNT_W-1:0]           vc_occupancy [NUM_VCS-1:0],
  output logic                       credit_valid,
  output logic [VC_W-1:0]            credit_vc_id,
  output logic                       protocol_err
);

  logic [NUM_VCS-1:0] fifo_full;
  logic [NUM_VCS-1:0] fifo_empty;
  logic [NUM_VCS-1:0] push_sel;
  logic [NUM_VCS-1:0] pop_sel;
  logic [VC_W-1:0]    pop_idx;
  logic               pop_legal;
  logic               vc_in_range;
  logic               err_now;

  // Pop decode with one-hot check, write demux with room check, and error detection.
  always_comb begin
    push_sel    = '0;
    pop_sel     = '0;
    pop_idx     = '0;
    err_now     = 1'b0;
    pop_legal   = $onehot0(vc_pop);
    vc_in_range = (int'(in_vc_id) < NUM_VCS);

    for (int v = 0; v < NUM_VCS; v++) begin
      if (pop_legal && vc_pop[v] && !fifo_empty[v]) begin
        pop_sel[v] = 1'b1;
        pop_idx    = VC_W'(v);
      end
      if (vc_pop[v] && fifo_empty[v]) begin
        err_now = 1'b1;
      end
    end

    if (!pop_legal) begin
      err_now = 1'b1;
    end

    if (in_valid) begin
      if (!vc_in_range) begin
        err_now = 1'b1;
      end else if (!fifo_full[in_vc_id] || pop_sel[in_vc_id]) begin
        push_sel[in_vc_id] = 1'b1;
      end else begin
        err_now = 1'b1;
      end
    end
  end

  // Credit return register plus the sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      credit_valid <= 1'b0;
      credit_vc_id <= '0;
      protocol_err <= 1'b0;
    end else begin
      credit_valid <= |pop_sel;
      if (|pop_sel) begin
        credit_vc_id <= pop_idx;
      end
      protocol_err <= protocol_err | err_now;
    end
  end

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    vc_fifo #(
      .WIDTH (FLIT_DATA_WIDTH),
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push_sel[v]),
      .pop       (pop_sel[v]),
      .push_data (in_data),
      .head      (vc_head_data[v]),
      .count     (vc_occupancy[v]),
      .full      (fifo_full[v]),
      .empty     (fifo_empty[v])
    );

    assign vc_head_valid[v] = !fifo_empty[v];
  end

endmodule
